prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the instruction-memory / program-counter interface: streams a program image into instruction memory, then releases the fetch unit.
- Drives the fetch unit's Reset through CPU_Reset. The processor stays frozen at PC 0 during any load and after a failed load.
- Sits between the host/testbench word stream and the instruction-memory write port.
- Each image is followed by one checksum word. The image is verified before the processor is released.

Parameters:
- IW, 9, instruction word width (matches instruction memory data width)
- AW, 9, instruction memory address width (matches the 9-bit PC)
- DEPTH, 512, instruction memory depth in words (must be 2**AW or less)
- HOLD_CYCLES, 2, cycles CPU_Reset stays high after a good checksum (at least 1)

Ports:
- CLK, input, 1, system clock; all state updates on the rising edge.
- Reset, input, 1, asynchronous active-high reset.
- Load_Start, input, 1, single-cycle request to begin a load. Sampled only in IDLE, RUN and ERROR.
- Load_Len, input, AW+1, number of program words in the image. Sampled together with Load_Start.
- In_Data, input, IW, incoming program or checksum word.
- In_Valid, input, 1, In_Data is valid.
- In_Ready, output, 1, loader accepts In_Data. A transfer occurs when In_Valid and In_Ready are both high.
- Mem_WE, output, 1, instruction memory write enable.
- Mem_Addr, output, AW, instruction memory write address.
- Mem_Data, output, IW, instruction memory write data.
- CPU_Reset, output, 1, connects to the fetch unit's Reset input.
- Busy, output, 1, high while in LOAD, CHECK or RELEASE.
- Done, output, 1, high in RUN.
- Error, output, 1, high in ERROR.

Behaviour:
- All outputs are registered.
- While Reset is asserted, and after its release:
  - State is IDLE.
  - CPU_Reset = 1.
  - In_Ready = 0, Mem_WE = 0, Mem_Addr = 0, Mem_Data = 0.
  - Busy = 0, Done = 0, Error = 0.
  - Word count = 0 and checksum = 0.
- IDLE state:
  - CPU_Reset = 1.
  - On Load_Start, the request is valid when 1 <= Load_Len <= DEPTH.
  - Valid request: go to LOAD, clear count and checksum, Busy = 1.
  - Invalid request: go to ERROR. No memory write occurs.
- LOAD state:
  - In_Ready = 1.
  - On each transfer, the next cycle has Mem_WE = 1, Mem_Addr = count, Mem_Data = word.
  - Each transfer also increments count and updates checksum to checksum XOR word.
  - Mem_WE is high for exactly one cycle per transfer. Back-to-back transfers give consecutive write cycles.
  - When the transfer with count = Load_Len-1 completes, go to CHECK.
  - In_Valid low simply stalls the load. There is no timeout.
- CHECK state:
  - In_Ready = 1 and no memory writes occur.
  - The next transferred word is compared with the accumulated checksum.
  - Equal: go to RELEASE. Different: go to ERROR.
- RELEASE state:
  - In_Ready = 0 and CPU_Reset = 1 for HOLD_CYCLES cycles.
  - Then go to RUN: CPU_Reset = 0, Done = 1, Busy = 0.
- RUN state:
  - CPU_Reset = 0, so the fetch unit executes from PC 0.
  - A valid Load_Start goes to LOAD.
  - CPU_Reset = 1 and Done = 0 from the next edge, before any memory write.
  - An invalid request goes to ERROR.
- ERROR state:
  - CPU_Reset = 1, Error = 1, In_Ready = 0.
  - Only Load_Start leaves this state, using the same validity rule as IDLE.
- Load_Start in LOAD, CHECK or RELEASE is ignored. The current load continues.
- Memory contents beyond Load_Len are left untouched.
- Mem_Addr never wraps: count saturates at DEPTH-1, which Load_Len <= DEPTH guarantees.
- Reset asserted mid-load:
  - The load is aborted immediately and outputs return to their reset values.
  - Memory contents already written are not restored.
  - CPU_Reset stays 1 until a later load succeeds.
- In_Ready deasserts on the edge where the last needed word is accepted. No extra word is ever consumed.

Decomposition:
- loader_pkg holds:
  - state enum {IDLE, LOAD, CHECK, RELEASE, RUN, ERROR}
  - IW and AW defaults
  - DEPTH constant
  - checksum seed (0)
- No sub-module is needed; FSM, counters and checksum live in one module.

Test Plan:
- Good load with no stalls:
  - Stimulus: Load_Start with Load_Len = 3, words 0x001, 0x002, 0x004, then checksum 0x007.
  - Required: writes at addresses 0, 1, 2 with that data on consecutive cycles.
  - Required: CPU_Reset falls 2 cycles after the checksum transfer, then Done = 1.
- Bad checksum:
  - Stimulus: same image with checksum 0x006.
  - Required: Error = 1, CPU_Reset stays 1, Done = 0, exactly 3 writes.
- Stalled stream:
  - Stimulus: In_Valid toggles 1-0-0-1-1 while loading the same image.
  - Required: writes only on transfer cycles, addresses stay in order, same final result as the no-stall case.
- Invalid length:
  - Stimulus: Load_Len = 0, and separately Load_Len = 513.
  - Required: immediate ERROR, no Mem_WE, In_Ready stays 0.
- Reload from RUN:
  - Stimulus: Load_Start in RUN with Load_Len = 1, word 0x1FF, checksum 0x1FF.
  - Required: CPU_Reset = 1 on the next edge, one write of 0x1FF to address 0, release after HOLD_CYCLES.
- Reset mid-load:
  - Stimulus: Reset asserted after 2 of 5 words.
  - Required: outputs return to reset values immediately, state IDLE, and a subsequent full load succeeds.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader.
package loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CHECK   = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam int IW_DEF          = 9;
  localparam int AW_DEF          = 9;
  localparam int DEPTH_DEF       = 512;
  localparam int HOLD_CYCLES_DEF = 2;

  // XOR checksum starts from this value at the beginning of every load
  localparam int CSUM_SEED       = 0;

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams an image into instruction memory, verifies an XOR
// checksum word and only then releases the fetch unit from reset.
module prog_loader
  import loader_pkg::*;
#(
  parameter int IW          = IW_DEF,
  parameter int AW          = AW_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Load_Start,
  input  logic [AW:0]   Load_Len,
  input  logic [IW-1:0] In_Data,
  input  logic          In_Valid,
  output logic          In_Ready,
  output logic          Mem_WE,
  output logic [AW-1:0] Mem_Addr,
  output logic [IW-1:0] Mem_Data,
  output logic          CPU_Reset,
  output logic          Busy,
  output logic          Done,
  output logic          Error
);

  state_t        state;
  logic [AW-1:0] count;
  logic [IW-1:0] csum;
  logic [AW:0]   len_r;
  logic [7:0]    hold_cnt;

  logic          len_ok;
  logic          xfer;
  logic          last_word;

  // Decode request validity, handshake and last-program-word conditions
  always_comb begin
    len_ok    = (Load_Len != (AW+1)'(0)) && (Load_Len <= (AW+1)'(DEPTH));
    xfer      = In_Valid && In_Ready;
    last_word = ({1'b0, count} == (len_r - (AW+1)'(1)));
  end

  // Loader FSM with all outputs registered
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      csum      <= IW'(CSUM_SEED);
      len_r     <= '0;
      hold_cnt  <= 8'd0;
      In_Ready  <= 1'b0;
      Mem_WE    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_Data  <= '0;
      CPU_Reset <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      // A write strobe lasts exactly one cycle unless re-armed below
      Mem_WE <= 1'b0;
      case (state)
        IDLE, RUN, ERROR: begin
          if (Load_Start) begin
            CPU_Reset <= 1'b1;
            Done      <= 1'b0;
            if (len_ok) begin
              state    <= LOAD;
              count    <= '0;
              csum     <= IW'(CSUM_SEED);
              len_r    <= Load_Len;
              In_Ready <= 1'b1;
              Busy     <= 1'b1;
              Error    <= 1'b0;
            end else begin
              state    <= ERROR;
              In_Ready <= 1'b0;
              Busy     <= 1'b0;
              Error    <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            Mem_WE   <= 1'b1;
            Mem_Addr <= count;
            Mem_Data <= In_Data;
            csum     <= csum ^ In_Data;
            // Address is bounded by Load_Len <= DEPTH, never wrap past the top
            if (count != AW'(DEPTH - 1)) begin
              count <= count + AW'(1);
            end
            if (last_word) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            In_Ready <= 1'b0;
            if (In_Data == csum) begin
              state    <= RELEASE;
              hold_cnt <= 8'd0;
            end else begin
              state <= ERROR;
              Busy  <= 1'b0;
              Error <= 1'b1;
            end
          end
        end
        RELEASE: begin
          if (hold_cnt == 8'(HOLD_CYCLES - 1)) begin
            state     <= RUN;
            CPU_Reset <= 1'b0;
            Done      <= 1'b1;
            Busy      <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          In_Ready  <= 1'b0;
          CPU_Reset <= 1'b1;
          Busy      <= 1'b0;
          Done      <= 1'b0;
          Error     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a cycle table of inputs and expected
// registered outputs, plus hand sequences for reset and length corners.
module tb_prog_loader;
  import loader_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       Load_Start = 1'b0;
  logic [9:0] Load_Len = 10'd0;
  logic [8:0] In_Data = 9'd0;
  logic       In_Valid = 1'b0;
  logic       In_Ready, Mem_WE, CPU_Reset, Busy, Done, Error;
  logic [8:0] Mem_Addr, Mem_Data;

  prog_loader dut (
    .CLK(CLK), .Reset(Reset), .Load_Start(Load_Start), .Load_Len(Load_Len),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
    .CPU_Reset(CPU_Reset), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ls;
    logic [9:0] len;
    logic       iv;
    logic [8:0] d;
    logic       rdy;
    logic       we;
    logic [8:0] addr;
    logic [8:0] data;
    logic       cpu;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic ls, input logic [9:0] len, input logic iv,
                              input logic [8:0] d, input logic rdy, input logic we,
                              input logic [8:0] addr, input logic [8:0] data,
                              input logic cpu, input logic busy, input logic done,
                              input logic err);
    vec_t v;
    v.ls = ls; v.len = len; v.iv = iv; v.d = d;
    v.rdy = rdy; v.we = we; v.addr = addr; v.data = data;
    v.cpu = cpu; v.busy = busy; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk9(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk1({tag, ".In_Ready"}, In_Ready, v.rdy);
    chk1({tag, ".Mem_WE"}, Mem_WE, v.we);
    chk1({tag, ".CPU_Reset"}, CPU_Reset, v.cpu);
    chk1({tag, ".Busy"}, Busy, v.busy);
    chk1({tag, ".Done"}, Done, v.done);
    chk1({tag, ".Error"}, Error, v.err);
    if (v.we) begin
      chk9({tag, ".Mem_Addr"}, Mem_Addr, v.addr);
      chk9({tag, ".Mem_Data"}, Mem_Data, v.data);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk1({tag, ".CPU_Reset"}, CPU_Reset, 1'b1);
    chk1({tag, ".In_Ready"}, In_Ready, 1'b0);
    chk1({tag, ".Mem_WE"}, Mem_WE, 1'b0);
    chk9({tag, ".Mem_Addr"}, Mem_Addr, 9'h000);
    chk9({tag, ".Mem_Data"}, Mem_Data, 9'h000);
    chk1({tag, ".Busy"}, Busy, 1'b0);
    chk1({tag, ".Done"}, Done, 1'b0);
    chk1({tag, ".Error"}, Error, 1'b0);
  endtask

  logic [8:0] img5 [5];

  initial begin
    // ---- reset values while Reset is held
    #1 Reset = 1'b1;
    tick();
    tick();
    check_reset_vals("rst_hold");
    Reset = 1'b0;
    tick();
    check_reset_vals("rst_after");

    // ---- Load_Len = DEPTH is accepted, then aborted by reset
    Load_Start = 1'b1; Load_Len = 10'd512;
    tick();
    Load_Start = 1'b0;
    chk1("len512.Busy", Busy, 1'b1);
    chk1("len512.In_Ready", In_Ready, 1'b1);
    chk1("len512.Error", Error, 1'b0);
    Reset = 1'b1;
    #1;
    check_reset_vals("len512_abort");
    tick();
    Reset = 1'b0;

    // ---- cycle table: good load, reload from RUN, bad checksum,
    //      invalid lengths, stalled load with an ignored Load_Start
    //            ls    len      iv    d       rdy   we    addr    data    cpu   busy  done  err
    tbl.push_back(mk(1'b1, 10'd3, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h001, 1'b1, 1'b1, 9'h000, 9'h001, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h002, 1'b1, 1'b1, 9'h001, 9'h002, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h004, 1'b1, 1'b1, 9'h002, 9'h004, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h007, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h0AA, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h055, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0));
    // reload from RUN, one word 0x1FF
    tbl.push_back(mk(1'b1, 10'd1, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h1FF, 1'b1, 1'b1, 9'h000, 9'h1FF, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h1FF, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0));
    // bad checksum 0x006
    tbl.push_back(mk(1'b1, 10'd3, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h001, 1'b1, 1'b1, 9'h000, 9'h001, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h002, 1'b1, 1'b1, 9'h001, 9'h002, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h004, 1'b1, 1'b1, 9'h002, 9'h004, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h006, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h007, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1));
    // invalid lengths 0 and 513 from ERROR
    tbl.push_back(mk(1'b1, 10'd0, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 10'd513, 1'b1, 9'h001, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1));
    // stalled load, In_Valid 1-0-0-1-1, Load_Start during LOAD ignored
    tbl.push_back(mk(1'b1, 10'd3, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h001, 1'b1, 1'b1, 9'h000, 9'h001, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 10'd0, 1'b0, 9'h0F0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b0, 9'h0F0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h002, 1'b1, 1'b1, 9'h001, 9'h002, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h004, 1'b1, 1'b1, 9'h002, 9'h004, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b1, 9'h007, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 10'd0, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0));

    foreach (tbl[i]) begin
      Load_Start = tbl[i].ls;
      Load_Len   = tbl[i].len;
      In_Valid   = tbl[i].iv;
      In_Data    = tbl[i].d;
      tick();
      check_vec($sformatf("vec%0d", i), tbl[i]);
    end
    Load_Start = 1'b0; In_Valid = 1'b0;

    // ---- reset after 2 of 5 words, then a full 5-word load
    img5[0] = 9'h101; img5[1] = 9'h0A5; img5[2] = 9'h033; img5[3] = 9'h1C0; img5[4] = 9'h00F;
    Load_Start = 1'b1; Load_Len = 10'd5;
    tick();
    Load_Start = 1'b0;
    In_Valid = 1'b1; In_Data = img5[0];
    tick();
    In_Data = img5[1];
    tick();
    In_Valid = 1'b0;
    chk9("midrst.pre_addr", Mem_Addr, 9'h001);
    #2 Reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    Reset = 1'b0;
    tick();
    check_reset_vals("midrst_idle");

    Load_Start = 1'b1; Load_Len = 10'd5;
    tick();
    Load_Start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      In_Valid = 1'b1; In_Data = img5[k];
      tick();
      chk1($sformatf("full.we%0d", k), Mem_WE, 1'b1);
      chk9($sformatf("full.addr%0d", k), Mem_Addr, 9'(k));
      chk9($sformatf("full.data%0d", k), Mem_Data, img5[k]);
    end
    In_Data = 9'h058;
    tick();
    In_Valid = 1'b0;
    chk1("full.ready_drop", In_Ready, 1'b0);
    chk1("full.no_write", Mem_WE, 1'b0);
    tick();
    chk1("full.hold_cpu", CPU_Reset, 1'b1);
    tick();
    chk1("full.cpu_release", CPU_Reset, 1'b0);
    chk1("full.done", Done, 1'b1);
    chk1("full.error", Error, 1'b0);

    // ---- invalid length straight from IDLE
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Load_Start = 1'b1; Load_Len = 10'd0;
    tick();
    Load_Start = 1'b0;
    chk1("idle_len0.Error", Error, 1'b1);
    chk1("idle_len0.In_Ready", In_Ready, 1'b0);
    chk1("idle_len0.Mem_WE", Mem_WE, 1'b0);
    chk1("idle_len0.CPU_Reset", CPU_Reset, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
